multdiv_unit: RTL

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_counter.sv | 47 ++++
 rtl/multdiv_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg -- shared definitions for the iterative multiply/divide unit.
// Holds the FSM state encoding, the default operand width and the width of
// the iteration counter. No ports.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter -- 6-bit up-counter with synchronous clear and a
// terminal-count flag, used to sequence the datapath iterations.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0), overrides en
//   en      : increment enable
//   tc      : high while count equals TC_VAL
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter logic [CNT_W-1:0] TC_VAL = 6'd32
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 6'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit -- iterative signed 32-bit multiplier (radix-2 Booth) and
// non-restoring divider sharing one accumulator/shift register pair.
// A start sampled in IDLE produces a one-cycle data_resultRDY pulse 33 edges
// later (32 iterations plus one finalise edge that enters DONE).
// Configuration: the divider datapath is built only when MULTDIV_DIV_EN is
// defined; otherwise ctrl_DIV completes immediately with result 0 and the
// exception flag set.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   data_operandA/B       : signed operands, latched at the start edge
//   ctrl_MULT / ctrl_DIV  : start requests (MULT has priority), IDLE only
//   data_result           : product low word or quotient, held until next DONE
//   data_exception        : overflow / divide-by-zero flag, held with result
//   data_resultRDY        : one-cycle pulse in the DONE cycle
//   busy                  : high while iterating (MUL or DIV state)
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // Accumulator carries two guard bits: Booth needs one for A - (-2^31),
    // the non-restoring remainder needs one for 2*R +/- D.
    localparam int AW = WIDTH + 2;
    localparam logic [CNT_W-1:0] ITER = CNT_W'(WIDTH);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  op_b_q,   op_b_d;
    logic [AW-1:0]     acc_q,    acc_d;
    logic [WIDTH-1:0]  qr_q,     qr_d;
    logic              qm1_q,    qm1_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              exc_q,    exc_d;
    logic              rdy_q,    rdy_d;
    logic              busy_q,   busy_d;

    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              cnt_tc_s;

    logic [AW-1:0]     m_ext_s;
    logic [AW-1:0]     booth_sum_s;

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0]  op_a_q,   op_a_d;
    logic [AW-1:0]     d_ext_s;
    logic [AW-1:0]     r_shift_s;
    logic [AW-1:0]     r_new_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction
`endif

    multdiv_counter #(
        .TC_VAL (ITER)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (cnt_tc_s)
    );

    // Booth step: {Q0, Q-1} = 01 adds M, 10 subtracts M.
    always_comb begin
        m_ext_s = {{2{op_b_q[WIDTH-1]}}, op_b_q};
        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum_s = acc_q + m_ext_s;
            2'b10:   booth_sum_s = acc_q - m_ext_s;
            default: booth_sum_s = acc_q;
        endcase
    end

`ifdef MULTDIV_DIV_EN
    // Non-restoring step: shift in the next dividend bit, then subtract the
    // divisor if the partial remainder is non-negative, else add it back.
    always_comb begin
        d_ext_s   = {2'b00, mag(op_b_q)};
        r_shift_s = {acc_q[AW-2:0], qr_q[WIDTH-1]};
        if (acc_q[AW-1]) begin
            r_new_s = r_shift_s + d_ext_s;
        end else begin
            r_new_s = r_shift_s - d_ext_s;
        end
    end
`endif

    // FSM next-state and datapath next-value logic.
    always_comb begin
        state_d   = state_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        qm1_d     = qm1_q;
        result_d  = result_q;
        exc_d     = exc_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
`ifdef MULTDIV_DIV_EN
        op_a_d    = op_a_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (ctrl_MULT) begin
                    state_d = ST_MUL;
                    op_b_d  = data_operandB;
                    acc_d   = '0;
                    qr_d    = data_operandA;
                    qm1_d   = 1'b0;
                end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
                    state_d = ST_DIV;
                    op_a_d  = data_operandA;
                    op_b_d  = data_operandB;
                    acc_d   = '0;
                    qr_d    = mag(data_operandA);
                    qm1_d   = 1'b0;
`else
                    // No divider: finish on this edge with the error flag.
                    state_d  = ST_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_tc_s) begin
                    state_d  = ST_DONE;
                    result_d = qr_q;
                    // Overflow when the high word is not the sign extension
                    // of the low word.
                    exc_d    = (acc_q[WIDTH-1:0] != {WIDTH{qr_q[WIDTH-1]}});
                end else begin
                    cnt_en_s = 1'b1;
                    acc_d    = {booth_sum_s[AW-1], booth_sum_s[AW-1:1]};
                    qr_d     = {booth_sum_s[0], qr_q[WIDTH-1:1]};
                    qm1_d    = qr_q[0];
                end
            end
            ST_DIV: begin
`ifdef MULTDIV_DIV_EN
                if (cnt_tc_s) begin
                    state_d = ST_DONE;
                    if (op_b_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if ((op_a_q == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                 (op_b_q == {WIDTH{1'b1}})) begin
                        result_d = {1'b1, {(WIDTH-1){1'b0}}};
                        exc_d    = 1'b1;
                    end else begin
                        result_d = (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]) ? (-qr_q) : qr_q;
                        exc_d    = 1'b0;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                    acc_d    = r_new_s;
                    qr_d     = {qr_q[WIDTH-2:0], ~r_new_s[AW-1]};
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rdy_d  = (state_d == ST_DONE);
        busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_b_q   <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            qm1_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            op_a_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            qr_q     <= qr_d;
            qm1_q    <= qm1_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
`ifdef MULTDIV_DIV_EN
            op_a_q   <= op_a_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
